// File: rtl/lookup_table_sched.sv
// lookup_table_sched: arbitrates one update writer and R lookup readers onto a
// shared ID-to-target table (one write port, one combinational read port) and
// clears the whole table after reset and whenever a flush is requested.
module lookup_table_sched #(
  parameter int R     = 4,
  parameter int D     = 16,
  parameter int WIDTH = 32,
  parameter int LOG_D = (D > 1) ? $clog2(D) : 1,
  parameter int LOG_R = (R > 1) ? $clog2(R) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wrVld_i,
  output logic             wrRdy_o,
  input  logic [LOG_D-1:0] newId,
  input  logic [WIDTH-1:0] newTarget,
  input  logic [R-1:0]     rdVld_i,
  output logic [R-1:0]     rdRdy_o,
  input  logic [LOG_D-1:0] lookupId [R],
  output logic [R-1:0]     rspVld_o,
  output logic [WIDTH-1:0] rspData_o,
  input  logic             flush_i,
  output logic             flushBusy_o,
  output logic             memWe_o,
  output logic [LOG_D-1:0] memWaddr_o,
  output logic [WIDTH-1:0] memWdata_o,
  output logic [LOG_D-1:0] memRaddr_o,
  input  logic [WIDTH-1:0] memRdata_i
);

  typedef enum logic [1:0] {RST_WAIT, FLUSH, RUN} state_e;

  localparam logic [LOG_D-1:0] LAST_ADDR = LOG_D'(D - 1);

  state_e             state_q, state_d;
  logic [LOG_D-1:0]   flush_cnt_q, flush_cnt_d;
  logic [LOG_R-1:0]   ptr_q, ptr_d;
  logic [R-1:0]       rsp_vld_q, rsp_vld_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic [R-1:0]       grant;
  logic               gnt_found;
  logic [LOG_R-1:0]   gnt_idx;
  logic [LOG_D-1:0]   rd_id;
  int                 scan_idx;

  // Sequencer: one idle cycle after reset, then a full clearing walk, then service.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RST_WAIT: begin
        state_d     = FLUSH;
        flush_cnt_d = '0;
      end
      FLUSH: begin
        if (flush_i) begin
          flush_cnt_d = '0;
        end else if (flush_cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      default: begin
        state_d     = RST_WAIT;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Write port: the flush walk owns it while busy, otherwise the update stream.
  always_comb begin
    wrRdy_o    = 1'b0;
    memWe_o    = 1'b0;
    memWaddr_o = '0;
    memWdata_o = '0;
    if (state_q == FLUSH) begin
      memWe_o    = 1'b1;
      memWaddr_o = flush_cnt_q;
    end else if (state_q == RUN) begin
      wrRdy_o    = wrVld_i;
      // Out-of-range ids are acknowledged but never reach the table.
      memWe_o    = wrVld_i && (int'(newId) < D);
      memWaddr_o = newId;
      memWdata_o = newTarget;
    end
  end

  // Round-robin arbiter: first requester after the last granted one wins.
  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    if (state_q == RUN) begin
      for (int k = 1; k <= R; k++) begin
        scan_idx = (int'(ptr_q) + k) % R;
        if (!gnt_found && rdVld_i[LOG_R'(scan_idx)]) begin
          gnt_found = 1'b1;
          gnt_idx   = LOG_R'(scan_idx);
        end
      end
      if (gnt_found) grant[gnt_idx] = 1'b1;
    end
  end

  assign rdRdy_o     = grant;
  assign rd_id       = lookupId[gnt_idx];
  assign memRaddr_o  = gnt_found ? rd_id : '0;
  assign flushBusy_o = (state_q != RUN);
  assign ptr_d       = gnt_found ? gnt_idx : ptr_q;

  // Response select: out-of-range reads give zero, a same-cycle write wins over the table.
  always_comb begin
    rsp_vld_d  = grant;
    rsp_data_d = rsp_data_q;
    if (gnt_found) begin
      if (int'(rd_id) >= D) begin
        rsp_data_d = '0;
      end else if (memWe_o && (memWaddr_o == rd_id)) begin
        rsp_data_d = memWdata_o;
      end else begin
        rsp_data_d = memRdata_i;
      end
    end
  end

  // State, flush counter, arbiter pointer and registered response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RST_WAIT;
      flush_cnt_q <= '0;
      ptr_q       <= LOG_R'(R - 1);
      rsp_vld_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ptr_q       <= ptr_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rspVld_o  = rsp_vld_q;
  assign rspData_o = rsp_data_q;

endmodule

// File: tb/tb_lookup_table_sched.sv
// Bench for lookup_table_sched: external table storage plus a spec-level model
// (table array, last-granted index) driving directed and random scenarios.
module tb_lookup_table_sched;
  localparam int R     = 4;
  localparam int D     = 12;
  localparam int W     = 32;
  localparam int LOG_D = 4;
  localparam int LOG_R = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             wrVld_i;
  logic             wrRdy_o;
  logic [LOG_D-1:0] newId;
  logic [W-1:0]     newTarget;
  logic [R-1:0]     rdVld_i;
  logic [R-1:0]     rdRdy_o;
  logic [LOG_D-1:0] lk_id [R];
  logic [R-1:0]     rspVld_o;
  logic [W-1:0]     rspData_o;
  logic             flush_i;
  logic             flushBusy_o;
  logic             memWe_o;
  logic [LOG_D-1:0] memWaddr_o;
  logic [W-1:0]     memWdata_o;
  logic [LOG_D-1:0] memRaddr_o;
  logic [W-1:0]     memRdata_i;

  always #5 clk = ~clk;

  lookup_table_sched #(.R(R), .D(D), .WIDTH(W)) dut (
    .clk(clk), .rstn(rstn),
    .wrVld_i(wrVld_i), .wrRdy_o(wrRdy_o), .newId(newId), .newTarget(newTarget),
    .rdVld_i(rdVld_i), .rdRdy_o(rdRdy_o), .lookupId(lk_id),
    .rspVld_o(rspVld_o), .rspData_o(rspData_o),
    .flush_i(flush_i), .flushBusy_o(flushBusy_o),
    .memWe_o(memWe_o), .memWaddr_o(memWaddr_o), .memWdata_o(memWdata_o),
    .memRaddr_o(memRaddr_o), .memRdata_i(memRdata_i)
  );

  // External table storage: write on the clock edge, combinational read.
  logic [W-1:0] store [D];
  always @(posedge clk) if (memWe_o && int'(memWaddr_o) < D) store[memWaddr_o] <= memWdata_o;
  assign memRdata_i = (int'(memRaddr_o) < D) ? store[memRaddr_o] : '0;

  // Reference model state.
  logic [W-1:0] ref_tab [D];
  int           ref_last;       // index of the last granted requester
  int           checks = 0;
  int           errors = 0;

  // Expectations for the cycle being applied.
  bit           exp_wr_rdy, exp_we;
  logic [R-1:0] exp_gnt;
  int           exp_gidx;
  logic [LOG_D-1:0] exp_raddr;
  logic [W-1:0] exp_next;
  logic [R-1:0] exp_rsp_vld;
  logic [W-1:0] exp_rsp_data;
  int           ap_wid;
  logic [W-1:0] ap_wt;

  task automatic model_reset();
    for (int i = 0; i < D; i++) ref_tab[i] = '0;
    ref_last     = R - 1;
    exp_rsp_vld  = '0;
    exp_rsp_data = '0;
  endtask

  // Drive one RUN-mode cycle and compute what the spec says should happen.
  task automatic apply(input bit wv, input int wid, input logic [W-1:0] wt, input logic [R-1:0] rv);
    int id;
    wrVld_i = wv; newId = LOG_D'(wid); newTarget = wt; rdVld_i = rv; flush_i = 1'b0;
    #1;
    ap_wid = wid; ap_wt = wt;
    exp_wr_rdy = wv;
    exp_we = wv && (wid < D);
    exp_gnt = '0; exp_gidx = -1; exp_raddr = '0;
    for (int k = 1; k <= R; k++) begin
      int idx = (ref_last + k) % R;
      if (exp_gidx < 0 && rv[idx]) exp_gidx = idx;
    end
    if (exp_gidx >= 0) begin
      exp_gnt[exp_gidx] = 1'b1;
      exp_raddr = lk_id[exp_gidx];
      id = int'(lk_id[exp_gidx]);
      if (id >= D) exp_next = '0;
      else if (exp_we && ap_wid == id) exp_next = wt;
      else exp_next = ref_tab[id];
    end
  endtask

  // Advance the model and the clock by one cycle.
  task automatic commit();
    if (exp_we) ref_tab[ap_wid] = ap_wt;
    if (exp_gidx >= 0) begin
      ref_last     = exp_gidx;
      exp_rsp_data = exp_next;
    end
    exp_rsp_vld = exp_gnt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_flush_done(input int expected_cycles, input string name);
    int n = 0;
    while (flushBusy_o === 1'b1 && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
    checks++;
    if (n != expected_cycles) begin errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, n, expected_cycles); end
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b0; wrVld_i = 1'b1; newId = 4'd1; newTarget = 32'h5555; rdVld_i = '1; flush_i = 1'b0;
    for (int r = 0; r < R; r++) lk_id[r] = LOG_D'(r);
    repeat (2) @(negedge clk);
    checks++; if (flushBusy_o !== 1'b1) begin errors++; $display("FAIL reset busy: got %b expected 1", flushBusy_o); end
    checks++; if (wrRdy_o !== 1'b0) begin errors++; $display("FAIL reset wrRdy: got %b expected 0", wrRdy_o); end
    checks++; if (rdRdy_o !== '0) begin errors++; $display("FAIL reset rdRdy: got %b expected 0", rdRdy_o); end
    checks++; if (rspVld_o !== '0 || rspData_o !== '0) begin errors++; $display("FAIL reset rsp: got %b/%h expected 0/0", rspVld_o, rspData_o); end
    checks++; if (memWe_o !== 1'b0 || memWaddr_o !== '0 || memWdata_o !== '0 || memRaddr_o !== '0) begin
      errors++; $display("FAIL reset memport: got we=%b wa=%h wd=%h ra=%h expected all 0", memWe_o, memWaddr_o, memWdata_o, memRaddr_o);
    end
    wrVld_i = 1'b0; rdVld_i = '0;
    rstn = 1'b1;
    n = 0;
    while (flushBusy_o === 1'b1 && n < 200) begin
      checks++;
      if (n == 0) begin
        if (memWe_o !== 1'b0) begin errors++; $display("FAIL init wait we: got %b expected 0", memWe_o); end
      end else if (memWe_o !== 1'b1 || int'(memWaddr_o) != n - 1 || memWdata_o !== '0) begin
        errors++; $display("FAIL init flush cycle %0d: got we=%b wa=%0d wd=%h expected 1/%0d/0", n, memWe_o, memWaddr_o, memWdata_o, n - 1);
      end
      @(posedge clk); @(negedge clk); n++;
    end
    checks++; if (n != D + 1) begin errors++; $display("FAIL init busy cycles: got %0d expected %0d", n, D + 1); end
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [R-1:0] one = 1;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < R; r++) lk_id[r] = LOG_D'($urandom_range(0, D - 1));
      if (c == 0) lk_id[0] = 4'd5;
      apply(1'b0, 0, '0, '1);
      checks++; if (rdRdy_o !== (one << (c % R))) begin errors++; $display("FAIL rr grant c%0d: got %b expected %b", c, rdRdy_o, one << (c % R)); end
      checks++; if (memRaddr_o !== exp_raddr) begin errors++; $display("FAIL rr raddr c%0d: got %h expected %h", c, memRaddr_o, exp_raddr); end
      commit();
      checks++; if (rspVld_o !== exp_rsp_vld || rspData_o !== exp_rsp_data) begin
        errors++; $display("FAIL rr rsp c%0d: got %b/%h expected %b/%h", c, rspVld_o, rspData_o, exp_rsp_vld, exp_rsp_data);
      end
    end
  endtask

  task automatic test_write_read();
    rdVld_i = '0;
    apply(1'b1, 3, 32'hDEADBEEF, 4'b0000);
    checks++; if (wrRdy_o !== 1'b1 || memWe_o !== 1'b1 || memWaddr_o !== 4'd3 || memWdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr port: got rdy=%b we=%b wa=%h wd=%h expected 1/1/3/deadbeef", wrRdy_o, memWe_o, memWaddr_o, memWdata_o);
    end
    commit();
    lk_id[2] = 4'd3;
    apply(1'b0, 0, '0, 4'b0100);
    checks++; if (rdRdy_o !== 4'b0100) begin errors++; $display("FAIL rd grant: got %b expected 0100", rdRdy_o); end
    commit();
    checks++; if (rspVld_o !== 4'b0100 || rspData_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd rsp: got %b/%h expected 0100/deadbeef", rspVld_o, rspData_o);
    end
    apply(1'b0, 0, '0, 4'b0000);
    commit();
    checks++; if (rspVld_o !== 4'b0000 || rspData_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rsp hold: got %b/%h expected 0000/deadbeef", rspVld_o, rspData_o);
    end
  endtask

  task automatic test_bypass();
    lk_id[0] = 4'd7;
    apply(1'b1, 7, 32'h1234, 4'b0001);
    checks++; if (rdRdy_o !== exp_gnt) begin errors++; $display("FAIL bypass grant: got %b expected %b", rdRdy_o, exp_gnt); end
    commit();
    checks++; if (rspVld_o !== exp_gnt || rspData_o !== 32'h1234) begin
      errors++; $display("FAIL bypass rsp: got %b/%h expected %b/00001234", rspVld_o, rspData_o, exp_gnt);
    end
  endtask

  task automatic test_out_of_range();
    apply(1'b1, 13, 32'hBAD0BAD0, 4'b0000);
    checks++; if (wrRdy_o !== 1'b1 || memWe_o !== 1'b0) begin errors++; $display("FAIL oor write: got rdy=%b we=%b expected 1/0", wrRdy_o, memWe_o); end
    commit();
    lk_id[3] = 4'd14;
    apply(1'b1, D - 1, 32'hCAFE0011, 4'b1000);
    checks++; if (memWe_o !== 1'b1 || memWaddr_o !== LOG_D'(D - 1)) begin errors++; $display("FAIL last id write: got we=%b wa=%h expected 1/%h", memWe_o, memWaddr_o, D - 1); end
    commit();
    checks++; if (rspVld_o !== 4'b1000 || rspData_o !== 32'h0) begin errors++; $display("FAIL oor read: got %b/%h expected 1000/0", rspVld_o, rspData_o); end
    lk_id[0] = LOG_D'(D - 1);
    apply(1'b0, 0, '0, 4'b0001);
    commit();
    checks++; if (rspData_o !== 32'hCAFE0011) begin errors++; $display("FAIL last id read: got %h expected cafe0011", rspData_o); end
  endtask

  task automatic test_random();
    bit wv;
    int wid;
    for (int c = 0; c < 300; c++) begin
      wv  = ($urandom_range(0, 1) == 1);
      wid = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      for (int r = 0; r < R; r++)
        lk_id[r] = LOG_D'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      apply(wv, wid, $urandom, R'($urandom));
      checks++;
      if (wrRdy_o !== exp_wr_rdy || memWe_o !== exp_we || rdRdy_o !== exp_gnt || memRaddr_o !== exp_raddr ||
          (exp_we && (int'(memWaddr_o) != ap_wid || memWdata_o !== ap_wt))) begin
        errors++; $display("FAIL rand comb c%0d: got rdy=%b we=%b gnt=%b ra=%h expected %b/%b/%b/%h", c, wrRdy_o, memWe_o, rdRdy_o, memRaddr_o, exp_wr_rdy, exp_we, exp_gnt, exp_raddr);
      end
      commit();
      checks++;
      if (rspVld_o !== exp_rsp_vld || rspData_o !== exp_rsp_data) begin
        errors++; $display("FAIL rand rsp c%0d: got %b/%h expected %b/%h", c, rspVld_o, rspData_o, exp_rsp_vld, exp_rsp_data);
      end
    end
  endtask

  task automatic test_flush();
    int n;
    int exp_cnt;
    lk_id[1] = 4'd2;
    apply(1'b1, 2, 32'hAA, 4'b0010);
    flush_i = 1'b1;
    #1;
    checks++; if (wrRdy_o !== 1'b1 || memWe_o !== 1'b1 || rdRdy_o !== exp_gnt) begin
      errors++; $display("FAIL flush-cycle accept: got rdy=%b we=%b gnt=%b expected 1/1/%b", wrRdy_o, memWe_o, rdRdy_o, exp_gnt);
    end
    commit();
    checks++; if (rspVld_o !== exp_rsp_vld || rspData_o !== 32'hAA) begin
      errors++; $display("FAIL flush-cycle rsp: got %b/%h expected %b/000000aa", rspVld_o, rspData_o, exp_rsp_vld);
    end
    wrVld_i = 1'b1; newId = 4'd5; newTarget = 32'h77; rdVld_i = '1;
    n = 0;
    while (flushBusy_o === 1'b1 && n < 200) begin
      flush_i = (n == 9);
      exp_cnt = (n < 10) ? n : n - 10;
      #1;
      checks++;
      if (wrRdy_o !== 1'b0 || rdRdy_o !== '0 || memWe_o !== 1'b1 || int'(memWaddr_o) != exp_cnt || memWdata_o !== '0) begin
        errors++; $display("FAIL flush walk n%0d: got rdy=%b gnt=%b we=%b wa=%0d wd=%h expected 0/0/1/%0d/0", n, wrRdy_o, rdRdy_o, memWe_o, memWaddr_o, memWdata_o, exp_cnt);
      end
      if (n == 1) begin
        checks++; if (rspVld_o !== '0 || rspData_o !== 32'hAA) begin errors++; $display("FAIL flush rsp hold: got %b/%h expected 0/000000aa", rspVld_o, rspData_o); end
      end
      @(posedge clk); @(negedge clk); n++;
    end
    checks++; if (n != 10 + D) begin errors++; $display("FAIL flush busy cycles: got %0d expected %0d", n, 10 + D); end
    for (int i = 0; i < D; i++) ref_tab[i] = '0;
    exp_rsp_vld = '0;
    lk_id[3] = 4'd2;
    apply(1'b0, 0, '0, 4'b1000);
    commit();
    checks++; if (rspVld_o !== 4'b1000 || rspData_o !== 32'h0) begin errors++; $display("FAIL post-flush read: got %b/%h expected 1000/0", rspVld_o, rspData_o); end
  endtask

  task automatic test_async_reset();
    lk_id[2] = 4'd0;
    apply(1'b1, 0, 32'h99, 4'b0100);
    @(posedge clk);
    #2;
    checks++; if (rspVld_o !== 4'b0100 || rspData_o !== 32'h99) begin errors++; $display("FAIL pre-reset rsp: got %b/%h expected 0100/00000099", rspVld_o, rspData_o); end
    rstn = 1'b0;
    #1;
    checks++; if (rspVld_o !== '0 || rspData_o !== '0 || flushBusy_o !== 1'b1 || memWe_o !== 1'b0 || rdRdy_o !== '0) begin
      errors++; $display("FAIL async reset: got vld=%b d=%h busy=%b we=%b gnt=%b expected 0/0/1/0/0", rspVld_o, rspData_o, flushBusy_o, memWe_o, rdRdy_o);
    end
    wrVld_i = 1'b0; rdVld_i = '0;
    @(negedge clk);
    rstn = 1'b1;
    wait_flush_done(D + 1, "reinit");
    model_reset();
    lk_id[0] = 4'd0;
    apply(1'b0, 0, '0, '1);
    checks++; if (rdRdy_o !== 4'b0001) begin errors++; $display("FAIL ptr after reset: got %b expected 0001", rdRdy_o); end
    commit();
    checks++; if (rspVld_o !== 4'b0001 || rspData_o !== '0) begin errors++; $display("FAIL read after reset: got %b/%h expected 0001/0", rspVld_o, rspData_o); end
  endtask

  initial begin
    for (int i = 0; i < D; i++) store[i] = $urandom;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_write_read();
    test_bypass();
    test_out_of_range();
    test_random();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
